// File: rtl/aes_keyslot_ctrl.sv
// Register front-end and start/wait/done sequencer for an AES-128 core.
// Holds write-only key slots with sticky locks, PT/IV staging and the CT result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a start write; idle status/result held
// ST_LOAD | operands snapshotted, start pulse presented to the core
// ST_WAIT | waiting for core_valid_i, debug abort or timeout
module aes_keyslot_ctrl #(
  parameter int NUM_KEYS       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_WIDTH     = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [7:0]            reglk_ctrl_i,
  input  logic                  acct_ctrl_i,
  input  logic                  debug_mode_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [63:0]           wdata_i,
  output logic [63:0]           rdata_o,
  output logic                  core_start_o,
  output logic [127:0]          core_key_o,
  output logic [127:0]          core_pt_o,
  output logic [127:0]          core_iv_o,
  input  logic                  core_valid_i,
  input  logic [127:0]          core_ct_i,
  output logic                  irq_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  NK4  = 4'(NUM_KEYS);
  localparam logic [31:0] NK32 = 32'(NUM_KEYS);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_t;
  state_t state;

  logic [31:0]         key_mem [NUM_KEYS][4];
  logic [NUM_KEYS-1:0] lock;
  logic [31:0]         pt [4];
  logic [31:0]         iv [4];
  logic [31:0]         ct [4];
  logic [31:0]         key_sel;
  logic                irq_en, done, busy;
  logic [1:0]          err;
  logic [TW-1:0]       timer;
  logic [127:0]        key_snap, pt_snap, iv_snap;

  logic [5:0]  word;
  logic [1:0]  sub;
  logic [3:0]  key_idx;
  logic [31:0] wd, rdata;
  logic        acc, wr, rd, key_hit;
  logic        ctrl_wr, start_req, ksel_wr, lock_wr, pt_wr, iv_wr, key_wr;
  logic        unused_bits;

  assign word    = address_i[8:3];
  assign sub     = word[1:0];
  assign key_idx = word[5:2] - 4'd4;
  assign key_hit = (word[5:2] >= 4'd4) && (key_idx < NK4);
  assign wd      = wdata_i[31:0];
  assign unused_bits = ^{address_i[ADDR_WIDTH-1:9], address_i[2:0], wdata_i[63:32]};

  assign acc = en_i & acct_ctrl_i;
  assign wr  = acc & we_i;
  assign rd  = acc & ~we_i;

  // Operand-affecting writes are frozen while an operation is in flight.
  assign ctrl_wr   = wr && word == 6'd0 && !reglk_ctrl_i[1];
  assign start_req = ctrl_wr && wd[0] && !busy;
  assign ksel_wr   = wr && word == 6'd2 && !reglk_ctrl_i[1] && !busy;
  assign lock_wr   = wr && word == 6'd3 && !reglk_ctrl_i[5];
  assign pt_wr     = wr && word[5:2] == 4'd1 && !reglk_ctrl_i[3] && !busy;
  assign iv_wr     = wr && word[5:2] == 4'd2 && !reglk_ctrl_i[3] && !busy;
  assign key_wr    = wr && key_hit && !reglk_ctrl_i[5] && !busy;

  always_comb begin
    rdata = 32'b0;
    if (rd) begin
      case (word[5:2])
        4'd0: begin
          case (sub)
            2'd0: if (!reglk_ctrl_i[0]) rdata = {31'b0, irq_en};
            2'd1: if (!reglk_ctrl_i[6]) rdata = {28'b0, err, done, busy};
            2'd2: if (!reglk_ctrl_i[0]) rdata = key_sel;
            2'd3: rdata = 32'(lock);
          endcase
        end
        4'd1: if (!reglk_ctrl_i[2]) rdata = pt[sub];
        4'd2: if (!reglk_ctrl_i[2]) rdata = iv[sub];
        4'd3: if (done && !reglk_ctrl_i[4]) rdata = ct[sub];
        default: rdata = 32'b0;
      endcase
    end
  end

  assign rdata_o    = {32'b0, rdata};
  assign core_key_o = debug_mode_i ? 128'b0 : key_snap;
  assign core_pt_o  = pt_snap;
  assign core_iv_o  = iv_snap;
  assign irq_o      = (done | (|err)) & irq_en;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      lock         <= '0;
      key_sel      <= 32'b0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      err          <= 2'b0;
      timer        <= '0;
      key_snap     <= 128'b0;
      pt_snap      <= 128'b0;
      iv_snap      <= 128'b0;
      core_start_o <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pt[i] <= 32'b0;
        iv[i] <= 32'b0;
        ct[i] <= 32'b0;
      end
      for (int k = 0; k < NUM_KEYS; k++)
        for (int i = 0; i < 4; i++) key_mem[k][i] <= 32'b0;
    end else begin
      core_start_o <= 1'b0;
      // Clear is applied first so a same-cycle FSM set of done/err wins.
      if (ctrl_wr) begin
        irq_en <= wd[1];
        if (wd[2]) begin
          done <= 1'b0;
          err  <= 2'b0;
        end
      end
      if (ksel_wr) key_sel <= wd;
      if (lock_wr) lock <= lock | wd[NUM_KEYS-1:0];
      if (pt_wr) pt[sub] <= wd;
      if (iv_wr) iv[sub] <= wd;
      for (int k = 0; k < NUM_KEYS; k++)
        if (key_wr && key_idx == 4'(k) && !lock[k]) key_mem[k][sub] <= wd;

      case (state)
        ST_IDLE: begin
          if (start_req) begin
            if (key_sel >= NK32) begin
              err  <= 2'd1;
              done <= 1'b0;
            end else if (debug_mode_i) begin
              err <= 2'd3;
            end else begin
              state        <= ST_LOAD;
              core_start_o <= 1'b1;
              busy         <= 1'b1;
              done         <= 1'b0;
              err          <= 2'b0;
              pt_snap      <= {pt[3], pt[2], pt[1], pt[0]};
              iv_snap      <= {iv[3], iv[2], iv[1], iv[0]};
              for (int k = 0; k < NUM_KEYS; k++)
                if (key_sel == 32'(k))
                  key_snap <= {key_mem[k][3], key_mem[k][2], key_mem[k][1], key_mem[k][0]};
              for (int i = 0; i < 4; i++) ct[i] <= 32'b0;
            end
          end
        end
        ST_LOAD: begin
          state <= ST_WAIT;
          timer <= T_LOAD;
        end
        ST_WAIT: begin
          if (debug_mode_i) begin
            err   <= 2'd3;
            busy  <= 1'b0;
            state <= ST_IDLE;
            for (int i = 0; i < 4; i++) ct[i] <= 32'b0;
          end else if (core_valid_i) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
            for (int i = 0; i < 4; i++) ct[i] <= core_ct_i[32*i +: 32];
          end else if (timer == '0) begin
            err   <= 2'd2;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_keyslot_ctrl.sv
// Self-checking bench for aes_keyslot_ctrl: scoreboarded register reads and
// start pulses, key-lock model, timeout edge, debug abort and access locks.
module tb_aes_keyslot_ctrl;
  localparam int NK = 4;
  localparam int TO = 16;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [7:0]   reglk_ctrl_i;
  logic         acct_ctrl_i, debug_mode_i, en_i, we_i;
  logic [63:0]  address_i, wdata_i, rdata_o;
  logic         core_start_o, core_valid_i, irq_o;
  logic [127:0] core_key_o, core_pt_o, core_iv_o, core_ct_i;

  always #5 clk_i = ~clk_i;

  aes_keyslot_ctrl #(.NUM_KEYS(NK), .TIMEOUT_CYCLES(TO), .ADDR_WIDTH(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .reglk_ctrl_i(reglk_ctrl_i),
    .acct_ctrl_i(acct_ctrl_i), .debug_mode_i(debug_mode_i), .en_i(en_i),
    .we_i(we_i), .address_i(address_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .core_start_o(core_start_o), .core_key_o(core_key_o), .core_pt_o(core_pt_o),
    .core_iv_o(core_iv_o), .core_valid_i(core_valid_i), .core_ct_i(core_ct_i),
    .irq_o(irq_o)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [127:0] start_q [$];
  logic [31:0]  rd_q [$];
  logic [31:0]  key_m [NK][4];
  logic [NK-1:0] lock_m;
  logic [31:0]  pt_m [4];

  task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_key(input int s);
    return {key_m[s][3], key_m[s][2], key_m[s][1], key_m[s][0]};
  endfunction

  // Every start pulse must match a queued start and carry the modelled key.
  always @(negedge clk_i) begin
    if (core_start_o === 1'b1) begin
      pulses++;
      chk_val("start_expected", 128'(start_q.size() > 0), 128'd1);
      if (start_q.size() > 0) chk_val("start_key", core_key_o, start_q.pop_front());
    end
  end

  task automatic reg_wr(input int w, input logic [31:0] d);
    en_i = 1'b1; we_i = 1'b1;
    address_i = 64'(w) << 3;
    wdata_i = {32'hA5A5A5A5, d};
    @(negedge clk_i);
    en_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic reg_rd(input string tag, input int w, input logic [31:0] exp);
    en_i = 1'b1; we_i = 1'b0;
    address_i = 64'(w) << 3;
    rd_q.push_back(exp);
    #1;
    chk_val(tag, rdata_o, {96'b0, rd_q.pop_front()});
    @(negedge clk_i);
    en_i = 1'b0;
  endtask

  task automatic key_wr(input int s, input int w, input logic [31:0] d);
    reg_wr(16 + 4*s + w, d);
    if (!lock_m[s]) key_m[s][w] = d;
  endtask

  // Leaves the caller at the negedge after the pulse, with the FSM in WAIT.
  task automatic do_start(input int sel);
    reg_wr(2, 32'(sel));
    start_q.push_back(exp_key(sel));
    reg_wr(0, 32'h3);
    #1 chk_val("start_pulse", 128'(core_start_o), 128'd1);
    @(negedge clk_i);
    #1 chk_val("start_width", 128'(core_start_o), 128'd0);
  endtask

  task automatic finish_op(input logic [127:0] ct);
    core_valid_i = 1'b1; core_ct_i = ct;
    @(negedge clk_i);
    core_valid_i = 1'b0;
  endtask

  task automatic model_reset();
    lock_m = '0;
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < 4; i++) key_m[k][i] = 32'b0;
  endtask

  initial begin
    int p0;
    rst_ni = 1'b0; reglk_ctrl_i = 8'h00; acct_ctrl_i = 1'b1; debug_mode_i = 1'b0;
    en_i = 1'b0; we_i = 1'b0; address_i = 64'b0; wdata_i = 64'b0;
    core_valid_i = 1'b0; core_ct_i = 128'b0;
    pt_m = '{32'h33221100, 32'h77665544, 32'hbbaa9988, 32'hffeeddcc};
    model_reset();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    chk_val("rst_irq", 128'(irq_o), 128'd0);
    chk_val("rst_start", 128'(core_start_o), 128'd0);
    chk_val("rst_rdata", rdata_o, 128'd0);
    reg_rd("rst_status", 1, 32'h0);
    reg_rd("rst_ctrl", 0, 32'h0);
    reg_rd("rst_lock", 3, 32'h0);
    reg_rd("rst_ct0", 12, 32'h0);

    // Basic encryption with slot 1
    key_wr(1, 0, 32'h0c0d0e0f); key_wr(1, 1, 32'h08090a0b);
    key_wr(1, 2, 32'h04050607); key_wr(1, 3, 32'h00010203);
    chk_val("model_key1", exp_key(1), 128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 4; i++) reg_wr(4 + i, pt_m[i]);
    reg_wr(0, 32'h2);
    chk_val("irq_idle", 128'(irq_o), 128'd0);
    do_start(1);
    chk_val("core_pt", core_pt_o, {pt_m[3], pt_m[2], pt_m[1], pt_m[0]});
    reg_rd("status_busy", 1, 32'h1);
    finish_op(128'h01234567_89abcdef_feedface_deadbeef);
    reg_rd("status_done", 1, 32'h2);
    reg_rd("ct_word0", 12, 32'hdeadbeef);
    reg_rd("ct_word3", 15, 32'h01234567);
    chk_val("irq_done", 128'(irq_o), 128'd1);

    // Slot locks
    reg_wr(3, 32'h2); lock_m |= 4'h2;
    reg_rd("lock_read", 3, 32'h2);
    key_wr(1, 0, 32'hffffffff);
    key_wr(0, 0, 32'h11112222); key_wr(0, 1, 32'h33334444);
    key_wr(0, 2, 32'h55556666); key_wr(0, 3, 32'h77778888);
    do_start(1);
    finish_op(128'h1);
    do_start(0);
    finish_op(128'h2);
    reg_rd("lock_status", 1, 32'h2);

    // KEY_SEL out of range
    reg_wr(2, NK);
    p0 = pulses;
    reg_wr(0, 32'h3);
    @(negedge clk_i);
    chk_val("badsel_nopulse", 128'(pulses), 128'(p0));
    reg_rd("badsel_status", 1, 32'h4);
    chk_val("badsel_irq", 128'(irq_o), 128'd1);
    reg_wr(0, 32'h4);
    reg_rd("clear_status", 1, 32'h0);
    chk_val("clear_irq", 128'(irq_o), 128'd0);

    // Timeout: still busy on the last WAIT cycle, error one cycle later
    do_start(0);
    repeat (TO - 1) @(negedge clk_i);
    reg_rd("to_edge_busy", 1, 32'h1);
    reg_rd("to_status", 1, 32'h8);
    reg_rd("to_ct0", 12, 32'h0);

    // Debug abort, late valid, busy PT write
    reg_wr(0, 32'h2);
    do_start(1);
    reg_wr(4, 32'h99999999);
    debug_mode_i = 1'b1;
    #1 chk_val("dbg_key_zero", core_key_o, 128'b0);
    @(negedge clk_i);
    debug_mode_i = 1'b0;
    #1 chk_val("key_snap_held", core_key_o, exp_key(1) == 128'b0 ? 128'd1 : exp_key(1));
    reg_rd("dbg_status", 1, 32'hc);
    finish_op(128'hcafe);
    reg_rd("late_valid_status", 1, 32'hc);
    reg_rd("late_valid_ct", 12, 32'h0);
    reg_rd("pt_busy_drop", 4, pt_m[0]);

    // Read/write locks and access enable
    reg_wr(0, 32'h6);
    do_start(0);
    finish_op(128'h0000_0000_0000_0000_0000_0000_1357_9bdf);
    reglk_ctrl_i = 8'h10;
    reg_rd("ct_rdlock", 12, 32'h0);
    reglk_ctrl_i = 8'h00;
    reg_rd("ct_unlocked", 12, 32'h13579bdf);
    reglk_ctrl_i = 8'h08;
    reg_wr(6, 32'h0badf00d);
    reglk_ctrl_i = 8'h00;
    reg_rd("pt_wrlock", 6, pt_m[2]);
    acct_ctrl_i = 1'b0;
    reg_wr(2, 32'h3);
    reg_wr(5, 32'h99999999);
    p0 = pulses;
    reg_wr(0, 32'h1);
    @(negedge clk_i);
    chk_val("acct_nopulse", 128'(pulses), 128'(p0));
    reg_rd("acct_read", 1, 32'h0);
    acct_ctrl_i = 1'b1;
    reg_rd("acct_ksel", 2, 32'h0);
    reg_rd("acct_pt1", 5, pt_m[1]);

    // Reset while waiting on the core
    do_start(0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    chk_val("midrst_irq", 128'(irq_o), 128'd0);
    reg_rd("midrst_status", 1, 32'h0);
    reg_rd("midrst_lock", 3, 32'h0);
    repeat (TO + 4) @(negedge clk_i);
    reg_rd("midrst_idle", 1, 32'h0);

    chk_val("start_q_drained", 128'(start_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_keyslot_ctrl.md
Name: aes_keyslot_ctrl

Overview:
Parametrised register front-end and sequencer for an AES-128 core. Holds NUM_KEYS write-only key slots with per-slot sticky locks, plus plaintext/IV staging and a ciphertext result register. Runs a start/wait/done handshake with the core, with timeout, debug abort and an interrupt. Sits between the axi_lite_interface outputs (address/en/we/data) and aes2_interface-style cores in the ariane tile.

Parameters:
NUM_KEYS, 4, number of 128-bit key slots (1..12)
TIMEOUT_CYCLES, 1024, max cycles in WAIT before error (>=2)
ADDR_WIDTH, 64, width of address_i

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
reglk_ctrl_i  in  8  register lock bits
acct_ctrl_i  in  1  access enable; en_i ignored when 0
debug_mode_i  in  1  debug mode; zeroes key path, aborts operation
en_i  in  1  register access strobe
we_i  in  1  write (1) / read (0)
address_i  in  ADDR_WIDTH  byte address; word index = address_i[8:3]
wdata_i  in  64  write data; bits [31:0] used
rdata_o  out  64  read data, combinational; [63:32] always 0
core_start_o  out  1  one-cycle start pulse to core
core_key_o  out  128  key snapshot
core_pt_o  out  128  plaintext snapshot
core_iv_o  out  128  IV snapshot
core_valid_i  in  1  core result valid (single-cycle)
core_ct_i  in  128  core result
irq_o  out  1  level interrupt = (done|err!=0) & irq_en

Behaviour:
- Access qualifier acc = en_i & acct_ctrl_i. Reads with !acc return 0.
- Word map: 0 CTRL (W: b0 start, b1 irq_en, b2 clear; R: {irq_en}); 1 STATUS (R: {err[1:0],done,busy} at bits 3:0); 2 KEY_SEL; 3 KEY_LOCK (W: OR into lock[NUM_KEYS-1:0]; R: lock); 4-7 PT word0..3 (word0 = bits 31:0); 8-11 IV word0..3; 12-15 CT word0..3 (RO); 16+4k+w key slot k word w (write-only, reads 0). Unmapped: writes ignored, reads 0.
- Write locks: reglk[1] blocks CTRL/KEY_SEL; reglk[3] blocks PT/IV; reglk[5] blocks key words and KEY_LOCK. Read locks (return 0): reglk[0] CTRL/KEY_SEL; reglk[6] STATUS; reglk[2] PT/IV; reglk[4] CT.
- A write to key slot k is dropped if lock[k]=1. Locks clear only on reset.
- While busy: writes to PT, IV, KEY_SEL, key words and start are ignored. irq_en and clear are still accepted.
- FSM states:
  - IDLE: on start write (cycle N):
    - if KEY_SEL>=NUM_KEYS: err=1, done=0, stay IDLE, no pulse.
    - else if debug_mode_i: err=3, no pulse.
    - else go to LOAD at N+1: snapshot key/pt/iv, clear done, err and CT, busy=1.
  - LOAD: core_start_o=1 for exactly this cycle (N+1); go to WAIT; timer cleared.
  - WAIT: on core_valid_i: CT<=core_ct_i, done=1, busy=0, go to IDLE (visible next cycle). If debug_mode_i (priority over valid): err=3, CT=0, go to IDLE. If timer reaches TIMEOUT_CYCLES-1 without valid: err=2, go to IDLE.
- core_valid_i outside WAIT is ignored.
- core_key_o is 0 whenever debug_mode_i=1, otherwise the snapshot. Later key writes never change an operation in progress.
- CT reads return 0 unless done=1.
- clear (CTRL b2) zeroes done and err. If the same cycle sets done or err, the set wins.
- Reset: state IDLE, all registers (keys, locks, pt, iv, CT, key_sel, irq_en, done, err, busy, timer) = 0. core_start_o=0, irq_o=0, rdata_o=0.
- Reset mid-WAIT aborts with no done and no irq.

Test Plan:
- Write slot1 key 000102..0f, PT, KEY_SEL=1, start -> core_start_o one pulse at N+1 with core_key_o=0x000102..0f; core_valid_i with ct=0xDEADBEEF.. -> STATUS=0b0010, CT word0 reads 0x..BEEF, irq_o=1 when irq_en=1.
- KEY_LOCK=0b0010 then write slot1 word0=0xFFFFFFFF -> encryption still uses original key; slot0 writes still effective; KEY_LOCK reads 0x2.
- KEY_SEL=NUM_KEYS(4), start -> no core_start_o, STATUS err=1 (0x4); clear -> STATUS=0.
- Start with no core_valid_i -> after TIMEOUT_CYCLES in WAIT, STATUS=0x8, busy=0, CT reads 0.
- debug_mode_i=1 during WAIT -> err=3 (0xC), core_key_o=0; late core_valid_i ignored; PT write while busy dropped.
- reglk[4]=1 -> CT reads 0 even when done; acct_ctrl_i=0 -> all writes ignored, reads 0.
